// File: rtl/mmio_bridge.sv
// CPU byte-bus bridge: RAM pass-through plus I/O window at 0x30000 (TX/RX FIFOs, cycle counter,
// program-stop flag). Define MMIO_RX_EN to compile in the RX FIFO and its read path.
module mmio_bridge #(
  parameter int unsigned TX_DEPTH_LOG2 = 3,
  parameter int unsigned RX_DEPTH_LOG2 = 3,
  parameter int unsigned FULL_MARGIN   = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] cpu_a,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_wr,
  output logic [7:0]  cpu_din,
  output logic        io_buffer_full,
  output logic [16:0] ram_a,
  output logic [7:0]  ram_din,
  output logic        ram_wr,
  input  logic [7:0]  ram_dout,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        program_stop,
  output logic        tx_overflow
);

  localparam int unsigned TxDepth = 1 << TX_DEPTH_LOG2;
  localparam logic [TX_DEPTH_LOG2:0] TxDepthW = (TX_DEPTH_LOG2 + 1)'(TxDepth);
  localparam logic [TX_DEPTH_LOG2:0] MarginW  = (TX_DEPTH_LOG2 + 1)'(FULL_MARGIN);

  typedef enum logic [2:0] {
    SelZero   = 3'd0,
    SelRam    = 3'd1,
    SelRxHead = 3'd2,
    SelCnt0   = 3'd3,
    SelCnt1   = 3'd4,
    SelCnt2   = 3'd5,
    SelCnt3   = 3'd6
  } sel_e;

  logic        io;
  logic [15:0] off;
  logic        io_wr, io_rd;

  assign io      = (cpu_a[17:16] == 2'b11);
  assign off     = cpu_a[15:0];
  assign io_wr   = rdy_in & io & cpu_wr;
  assign io_rd   = rdy_in & io & ~cpu_wr;
  assign ram_a   = cpu_a[16:0];
  assign ram_din = cpu_dout;
  assign ram_wr  = cpu_wr & ~io & rdy_in;

  // TX FIFO
  logic [7:0]               tx_mem [TxDepth];
  logic [TX_DEPTH_LOG2-1:0] tx_wptr_q, tx_rptr_q;
  logic [TX_DEPTH_LOG2:0]   tx_count_q;
  logic                     tx_full, tx_req, tx_push, tx_pop, tx_drop;
  logic [7:0]               tx_wdata;

  assign tx_full        = (tx_count_q == TxDepthW);
  assign tx_valid       = (tx_count_q != '0);
  assign tx_data        = tx_mem[tx_rptr_q];
  assign io_buffer_full = ((TxDepthW - tx_count_q) <= MarginW);
  assign tx_pop         = tx_valid & tx_ready;
  // 0x30004 stores a 0x00 terminator and bypasses the zero-ignore rule
  assign tx_req         = io_wr & (((off == 16'h0000) & (cpu_dout != 8'h00)) | (off == 16'h0004));
  assign tx_push        = tx_req & (~tx_full | tx_pop);
  assign tx_drop        = tx_req & tx_full & ~tx_pop;
  assign tx_wdata       = (off == 16'h0004) ? 8'h00 : cpu_dout;

  always_ff @(posedge clk_in) begin
    if (tx_push) tx_mem[tx_wptr_q] <= tx_wdata;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      tx_count_q <= '0;
    end else begin
      if (tx_push) tx_wptr_q <= tx_wptr_q + 1'b1;
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + 1'b1;
      tx_count_q <= tx_count_q + {{TX_DEPTH_LOG2{1'b0}}, tx_push}
                               - {{TX_DEPTH_LOG2{1'b0}}, tx_pop};
    end
  end

  // RX FIFO and popped-byte register
  logic [7:0] rx_byte;
  logic       unused_bits;

`ifdef MMIO_RX_EN
  localparam int unsigned RxDepth = 1 << RX_DEPTH_LOG2;
  localparam logic [RX_DEPTH_LOG2:0] RxDepthW = (RX_DEPTH_LOG2 + 1)'(RxDepth);

  logic [7:0]               rx_mem [RxDepth];
  logic [RX_DEPTH_LOG2-1:0] rx_wptr_q, rx_rptr_q;
  logic [RX_DEPTH_LOG2:0]   rx_count_q;
  logic [7:0]               rx_byte_q;
  logic                     rx_rd, rx_empty, rx_full, rx_push, rx_pop;

  assign rx_rd    = io_rd & (off == 16'h0000);
  assign rx_empty = (rx_count_q == '0);
  assign rx_full  = (rx_count_q == RxDepthW);
  assign rx_pop   = rx_rd & ~rx_empty;
  assign rx_push  = rx_valid & (~rx_full | rx_pop);
  assign rx_byte  = rx_byte_q;

  always_ff @(posedge clk_in) begin
    if (rx_push) rx_mem[rx_wptr_q] <= rx_data;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rx_wptr_q  <= '0;
      rx_rptr_q  <= '0;
      rx_count_q <= '0;
      rx_byte_q  <= 8'h00;
    end else begin
      if (rx_push) rx_wptr_q <= rx_wptr_q + 1'b1;
      if (rx_pop)  rx_rptr_q <= rx_rptr_q + 1'b1;
      if (rx_rd)   rx_byte_q <= rx_pop ? rx_mem[rx_rptr_q] : 8'h00;
      rx_count_q <= rx_count_q + {{RX_DEPTH_LOG2{1'b0}}, rx_push}
                               - {{RX_DEPTH_LOG2{1'b0}}, rx_pop};
    end
  end

  assign unused_bits = ^cpu_a[31:18];
`else
  assign rx_byte     = 8'h00;
  assign unused_bits = ^{cpu_a[31:18], rx_data, rx_valid, RX_DEPTH_LOG2[0]};
`endif

  // Read select, counter, snapshot and sticky flags
  sel_e        sel_q, sel_d;
  logic [31:0] cnt_q, cnt_snap_q;
  logic        stop_q, ovf_q;

  always_comb begin
    sel_d = sel_q;
    if (rdy_in) begin
      if (!io) begin
        sel_d = SelRam;
      end else if (cpu_wr) begin
        sel_d = SelZero;
      end else begin
        case (off)
`ifdef MMIO_RX_EN
          16'h0000: sel_d = SelRxHead;
`endif
          16'h0004: sel_d = SelCnt0;
          16'h0005: sel_d = SelCnt1;
          16'h0006: sel_d = SelCnt2;
          16'h0007: sel_d = SelCnt3;
          default:  sel_d = SelZero;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sel_q      <= SelZero;
      cnt_q      <= '0;
      cnt_snap_q <= '0;
      stop_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      sel_q <= sel_d;
      if (rdy_in) cnt_q <= cnt_q + 32'd1;
      if (io_rd && off == 16'h0004) cnt_snap_q <= cnt_q;
      if (io_wr && off == 16'h0004) stop_q <= 1'b1;
      if (tx_drop) ovf_q <= 1'b1;
    end
  end

  assign program_stop = stop_q;
  assign tx_overflow  = ovf_q;

  always_comb begin
    cpu_din = 8'h00;
    unique case (sel_q)
      SelRam:    cpu_din = ram_dout;
      SelRxHead: cpu_din = rx_byte;
      SelCnt0:   cpu_din = cnt_snap_q[7:0];
      SelCnt1:   cpu_din = cnt_snap_q[15:8];
      SelCnt2:   cpu_din = cnt_snap_q[23:16];
      SelCnt3:   cpu_din = cnt_snap_q[31:24];
      default:   cpu_din = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_mmio_bridge.sv
// Bench for mmio_bridge: queue-based reference model checked every cycle, directed scenarios
// with literal expectations, and a long randomized run with a mid-run reset.
module tb_mmio_bridge;

  localparam int TxDepth = 8;
  localparam int RxDepth = 8;
  localparam int Margin  = 2;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b0;
  logic [31:0] cpu_a = '0;
  logic [7:0]  cpu_dout = '0;
  logic        cpu_wr = 1'b0;
  logic [7:0]  cpu_din;
  logic        io_buffer_full;
  logic [16:0] ram_a;
  logic [7:0]  ram_din;
  logic        ram_wr;
  logic [7:0]  ram_dout = '0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        program_stop;
  logic        tx_overflow;

  mmio_bridge #(
    .TX_DEPTH_LOG2(3),
    .RX_DEPTH_LOG2(3),
    .FULL_MARGIN  (Margin)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .cpu_a         (cpu_a),
    .cpu_dout      (cpu_dout),
    .cpu_wr        (cpu_wr),
    .cpu_din       (cpu_din),
    .io_buffer_full(io_buffer_full),
    .ram_a         (ram_a),
    .ram_din       (ram_din),
    .ram_wr        (ram_wr),
    .ram_dout      (ram_dout),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .program_stop  (program_stop),
    .tx_overflow   (tx_overflow)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: FIFOs as queues, the read result as "what was asked for last"
  logic [7:0]  txq[$];
  logic [7:0]  rxq[$];
  logic [31:0] m_cnt, m_snap;
  logic [7:0]  m_rx_byte;
  int          m_kind;  // 0 zero, 1 ram, 2 rx byte, 3..6 snapshot byte 0..3
  bit          m_stop, m_ovf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    txq.delete();
    rxq.delete();
    m_cnt = 0; m_snap = 0; m_rx_byte = 0; m_kind = 0; m_stop = 0; m_ovf = 0;
  endtask

  function automatic logic [7:0] exp_din();
    case (m_kind)
      1:       return ram_dout;
      2:       return m_rx_byte;
      3:       return m_snap[7:0];
      4:       return m_snap[15:8];
      5:       return m_snap[23:16];
      6:       return m_snap[31:24];
      default: return 8'h00;
    endcase
  endfunction

  task automatic compare_model();
    bit io;
    io = (cpu_a[17:16] == 2'b11);
    chk("cpu_din", cpu_din, exp_din());
    chk("tx_valid", tx_valid, txq.size() > 0);
    if (txq.size() > 0) chk("tx_data", tx_data, txq[0]);
    chk("io_buffer_full", io_buffer_full, (TxDepth - txq.size()) <= Margin);
    chk("program_stop", program_stop, m_stop);
    chk("tx_overflow", tx_overflow, m_ovf);
    chk("ram_wr", ram_wr, cpu_wr && !io && rdy_in);
    chk("ram_a", ram_a, cpu_a[16:0]);
    chk("ram_din", ram_din, cpu_dout);
  endtask

  task automatic model_update();
    bit          io, tx_pop, tx_req, rd;
    logic [15:0] off;
    int          tx_before;
    io        = (cpu_a[17:16] == 2'b11);
    off       = cpu_a[15:0];
    rd        = rdy_in && io && !cpu_wr;
    tx_before = txq.size();
    tx_pop    = (tx_before > 0) && tx_ready;
    tx_req    = rdy_in && io && cpu_wr && ((off == 0 && cpu_dout != 0) || off == 4);
    if (tx_pop) void'(txq.pop_front());
    if (tx_req) begin
      if (tx_before < TxDepth || tx_pop) txq.push_back(off == 4 ? 8'h00 : cpu_dout);
      else m_ovf = 1;
    end
    if (rdy_in && io && cpu_wr && off == 4) m_stop = 1;
`ifdef MMIO_RX_EN
    begin
      int rx_before;
      bit rx_pop;
      rx_before = rxq.size();
      rx_pop    = rd && off == 0 && rx_before > 0;
      if (rd && off == 0) m_rx_byte = rx_pop ? rxq.pop_front() : 8'h00;
      if (rx_valid && (rx_before < RxDepth || rx_pop)) rxq.push_back(rx_data);
    end
`endif
    if (rd && off == 4) m_snap = m_cnt;
    if (rdy_in) begin
      m_cnt = m_cnt + 1;
      if (!io) m_kind = 1;
      else if (cpu_wr) m_kind = 0;
`ifdef MMIO_RX_EN
      else if (off == 0) m_kind = 2;
`endif
      else if (off >= 4 && off <= 7) m_kind = 3 + int'(off) - 4;
      else m_kind = 0;
    end
  endtask

  task automatic drive(input logic [31:0] a, input bit wr, input logic [7:0] d, input bit rdy,
                       input bit txr, input bit rxv, input logic [7:0] rxd);
    cpu_a = a; cpu_wr = wr; cpu_dout = d; rdy_in = rdy;
    tx_ready = txr; rx_valid = rxv; rx_data = rxd;
    ram_dout = 8'($urandom);
  endtask

  task automatic tick();
    @(negedge clk_in);
    compare_model();
    @(posedge clk_in);
    model_update();
    #1;
  endtask

  task automatic idle(input int n, input bit rdy, input bit txr);
    for (int i = 0; i < n; i++) begin
      drive(32'h0000_0000, 1'b0, 8'h00, rdy, txr, 1'b0, 8'h00);
      tick();
    end
  endtask

  task automatic do_reset();
    drive(32'h0000_0000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    #2;
    rst_in = 1'b0;
    #1;
    chk("rst cpu_din", cpu_din, 8'h00);
    chk("rst tx_valid", tx_valid, 1'b0);
    chk("rst io_buffer_full", io_buffer_full, 1'b0);
    chk("rst ram_wr", ram_wr, 1'b0);
    chk("rst program_stop", program_stop, 1'b0);
    chk("rst tx_overflow", tx_overflow, 1'b0);
    @(posedge clk_in);
    #3;
    rst_in = 1'b1;
    model_reset();
  endtask

  function automatic logic [31:0] rand_addr();
    logic [15:0] offs [11];
    logic [31:0] a;
    offs = '{16'h0000, 16'h0000, 16'h0000, 16'h0004, 16'h0004, 16'h0005,
             16'h0006, 16'h0007, 16'h0001, 16'h0008, 16'h0100};
    a = $urandom;
    if ($urandom_range(0, 2) != 0) a[17:0] = {2'b11, offs[$urandom_range(0, 10)]};
    else a[17:16] = 2'($urandom_range(0, 2));
    return a;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    do_reset();

    // RAM path
    drive(32'h0000_0123, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00);
    #1;
    chk("ram write strobe", ram_wr, 1'b1);
    chk("ram write addr", ram_a, 17'h00123);
    chk("ram write data", ram_din, 8'hA5);
    tick();
    drive(32'h0000_0123, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
    #1;
    chk("ram read no strobe", ram_wr, 1'b0);
    tick();
    drive(32'h0003_0008, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
    ram_dout = 8'h5A;
    #1;
    chk("ram read data", cpu_din, 8'h5A);
    tick();

    // TX with zero-ignore
    do_reset();
    drive(32'h0003_0000, 1'b1, 8'h48, 1'b1, 1'b1, 1'b0, 8'h00); tick();
    chk("tx first valid", tx_valid, 1'b1);
    chk("tx first data", tx_data, 8'h48);
    drive(32'h0003_0000, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00); tick();
    chk("tx zero ignored", tx_valid, 1'b0);
    drive(32'h0003_0000, 1'b1, 8'h49, 1'b1, 1'b1, 1'b0, 8'h00); tick();
    chk("tx second data", tx_data, 8'h49);
    idle(2, 1'b1, 1'b1);
    chk("tx no overflow", tx_overflow, 1'b0);

    // TX backpressure
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(32'h0003_0000, 1'b1, 8'(8'h60 + i), 1'b1, 1'b0, 1'b0, 8'h00);
      tick();
      if (i == 4) chk("bp full after 5", io_buffer_full, 1'b0);
      if (i == 5) chk("bp full after 6", io_buffer_full, 1'b1);
      if (i == 7) chk("bp ovf after 8", tx_overflow, 1'b0);
    end
    chk("bp ovf after 9", tx_overflow, 1'b1);
    chk("bp head", tx_data, 8'h60);
    idle(10, 1'b1, 1'b1);
    chk("bp drained", tx_valid, 1'b0);

    // Counter snapshot and freeze
    do_reset();
    idle(100, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(32'h0003_0004 + i, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
      tick();
      chk("cnt byte", cpu_din, (i == 0) ? 8'd100 : 8'h00);
    end
    idle(10, 1'b0, 1'b0);
    drive(32'h0003_0004, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00); tick();
    chk("cnt frozen", cpu_din, 8'd104);

    // Program stop
    do_reset();
    drive(32'h0003_0004, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00); tick();
    chk("stop set", program_stop, 1'b1);
    chk("stop tx valid", tx_valid, 1'b1);
    chk("stop tx data", tx_data, 8'h00);
    idle(5, 1'b1, 1'b1);
    chk("stop sticky", program_stop, 1'b1);

    // RX
    do_reset();
    drive(32'h0000_0000, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h31); tick();
    drive(32'h0000_0000, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h32); tick();
    for (int i = 0; i < 3; i++) begin
      drive(32'h0003_0000, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
      tick();
`ifdef MMIO_RX_EN
      chk("rx read", cpu_din, (i == 0) ? 8'h31 : (i == 1) ? 8'h32 : 8'h00);
`else
      chk("rx read", cpu_din, 8'h00);
`endif
    end

    // Randomized run with a reset in the middle
    for (int i = 0; i < 3000; i++) begin
      bit txr;
      logic [7:0] d;
      if (i == 1500) do_reset();
      txr = ((i % 400) < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
      d   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      drive(rand_addr(), $urandom_range(0, 1) == 1, d, $urandom_range(0, 9) != 0, txr,
            $urandom_range(0, 9) < 3, 8'($urandom));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mmio_bridge.md
# mmio_bridge

Memory-mapped bus bridge between the CPU core's byte bus and its neighbours: the 128 KB synchronous RAM and the UART. Decodes `cpu_a[17:16]`, routes RAM accesses straight through, and services the I/O window at 0x30000. The I/O window comprises a TX byte FIFO feeding the UART, an optional RX FIFO, a free-running cycle counter, and the program-stop flag. Generates `io_buffer_full` back to the core.

## Interface
Parameters:
- `TX_DEPTH_LOG2`, 3: TX FIFO depth is 2^N bytes.
- `RX_DEPTH_LOG2`, 3: RX FIFO depth is 2^N bytes.
- `FULL_MARGIN`, 2: `io_buffer_full` asserts when the TX FIFO has ≤ this many free slots. Legal range 1..2^TX_DEPTH_LOG2-1.

Ports:
- `clk_in` in 1: single clock, rising edge.
- `rst_in` in 1: reset, asynchronous, active-low.
- `rdy_in` in 1: core enable; CPU-side state frozen when low.
- `cpu_a` in 32: core address; bits 17:0 decoded.
- `cpu_dout` in 8: core write data.
- `cpu_wr` in 1: 1 = write, 0 = read.
- `cpu_din` out 8: read data returned to the core.
- `io_buffer_full` out 1: TX FIFO nearly full.
- `ram_a` out 17: `cpu_a[16:0]`, combinational.
- `ram_din` out 8: `cpu_dout`, combinational.
- `ram_wr` out 1: RAM write strobe.
- `ram_dout` in 8: RAM read data, valid one cycle after the address.
- `tx_data` out 8, `tx_valid` out 1, `tx_ready` in 1: UART TX valid/ready.
- `rx_data` in 8, `rx_valid` in 1: UART RX one-cycle push.
- `program_stop` out 1: sticky; set by a write to 0x30004.
- `tx_overflow` out 1: sticky; set when a TX push is dropped.

## Operation
- Decode: `io = (cpu_a[17:16] == 2'b11)`. RAM region is everything else.
- `ram_wr = cpu_wr & ~io & rdy_in`.
- Read select register `sel_q`, loaded every cycle `rdy_in` is high. Encodings: RAM, RXHEAD, CNT0, CNT1, CNT2, CNT3, ZERO.
- `cpu_din` is combinational from `sel_q`:
  - RAM selects `ram_dout`.
  - RXHEAD selects the popped byte, registered.
  - CNTn selects byte n of `cnt_snap`, little-endian.
  - ZERO selects 0x00.
- Cycle counter `cnt`: 32 bits, +1 per cycle with `rdy_in` high, wraps at 2^32.
- A read of 0x30004 loads `cnt_snap <= cnt`. Reads of 0x30005..0x30007 return snapshot bytes 1..3 and do not reload the snapshot.
- Write 0x30000:
  - Data nonzero: push to TX FIFO.
  - Data 0x00: ignored.
  - FIFO full with no pop in the same cycle: data dropped and `tx_overflow` set.
- Write 0x30004: push 0x00 to TX FIFO (zero-ignore bypassed) and set `program_stop`. Full/overflow handling is the same as for 0x30000.
- Read 0x30000: pop RX FIFO head into the data register. If the FIFO is empty, return 0x00 with no pop.
- Other I/O addresses: writes ignored, reads return 0x00.
- TX drain:
  - `tx_valid = !tx_empty`; `tx_data` = FIFO head.
  - Pop on `tx_valid & tx_ready`.
  - Drain continues regardless of `rdy_in`.
- RX capture: on `rx_valid`, push `rx_data`. Dropped silently when the RX FIFO is full, unless a pop occurs in the same cycle. Capture continues regardless of `rdy_in`.
- FIFOs: circular buffers with pointer wrap, count width N+1. Simultaneous push and pop is legal at any occupancy, including full and empty.
- `io_buffer_full = (2^TX_DEPTH_LOG2 - tx_count) <= FULL_MARGIN`. Combinational from the registered count.

## Timing
- Reset (asynchronous, `rst_in` = 0) drives these to zero: all FIFO pointers and counts, `cnt`, `cnt_snap`, `sel_q` (ZERO), the data register, `program_stop`, `tx_overflow`.
- Resulting outputs in reset: `cpu_din` = 0, `tx_valid` = 0, `io_buffer_full` = 0, `ram_wr` = 0.
- Reset mid-transfer discards all FIFO contents.
- Read latency: data appears on `cpu_din` in cycle t+1 for an address presented in cycle t.
- Writes complete in one cycle. A TX push in cycle t makes `tx_valid` high in t+1.
- `rdy_in` low in cycle t: no CPU-side push or pop, `sel_q` and `cnt` hold, `ram_wr` = 0. The UART sides still operate.
- The margin covers the core's in-flight store. `FULL_MARGIN` ≥ 1 guarantees no drop when the core honours `io_buffer_full`.

## Configuration
- `MMIO_RX_EN` defined: RX FIFO, `rx_data`/`rx_valid` capture, and RXHEAD select are compiled in.
- `MMIO_RX_EN` undefined:
  - No RX storage.
  - `rx_*` inputs are ignored.
  - Reads of 0x30000 return 0x00.
  - `RX_DEPTH_LOG2` is unused.

## Test plan
- RAM path: write 0xA5 to 0x00123, then read 0x00123 → `ram_wr` = 1 only in the write cycle, `ram_a` = 0x00123, `cpu_din` = `ram_dout` one cycle after the read.
- TX with zero-ignore: writes 0x48, 0x00, 0x49 to 0x30000 with `tx_ready` = 1 → `tx_data` sequence 0x48, 0x49 only; no overflow.
- TX backpressure (DEPTH 8, MARGIN 2, `tx_ready` = 0): push 6 bytes → `io_buffer_full` = 1 after the 6th. 3 more pushes → 2 accepted, 9th dropped, `tx_overflow` = 1.
- Counter: hold `rdy_in` = 1 for 100 cycles after reset, then read 0x30004..0x30007 → bytes form 100 (snapshot at the 0x30004 read), high bytes 0x00. Toggle `rdy_in` low for 10 cycles → count frozen.
- Program stop: write 0x00 to 0x30004 → `program_stop` = 1 next cycle, 0x00 emitted on `tx_data`, sticky until `rst_in` = 0.
- RX (`MMIO_RX_EN`): inject 0x31, 0x32, then read 0x30000 three times → 0x31, 0x32, 0x00. Without the macro → 0x00, 0x00, 0x00.
